// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int DEF_AW   = 4;
    localparam int DEF_NSRC = 3;

    // Execute-stage operand mux selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage source port (M result beats W result).
// Latency: combinational, same cycle.
// Backpressure: none; pure compare logic.
//
// Ports:
//   i_ra, i_rval           execute source address / port actually read
//   i_wa_m, i_regwrite_m   memory-stage destination / write enable
//   i_wa_w, i_regwrite_w   writeback-stage destination / write enable
//   o_fwd                  FWD_RF / FWD_W / FWD_M
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int PC_REG = 15
) (
    input  logic [AW-1:0] i_ra,
    input  logic          i_rval,
    input  logic [AW-1:0] i_wa_m,
    input  logic          i_regwrite_m,
    input  logic [AW-1:0] i_wa_w,
    input  logic          i_regwrite_w,
    output logic [1:0]    o_fwd
);

    localparam logic [AW-1:0] PC_A = AW'(PC_REG);

    logic w_valid;
    logic w_hit_m;
    logic w_hit_w;

    // The PC is produced by the fetch path, never by a pipeline register write
    assign w_valid = i_rval && (i_ra != PC_A);
    assign w_hit_m = w_valid && i_regwrite_m && (i_ra == i_wa_m);
    assign w_hit_w = w_valid && i_regwrite_w && (i_ra == i_wa_w);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m) begin
            o_fwd = FWD_M;
        end else if (w_hit_w) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding, load-use stall,
// multi-cycle execute freeze, branch flush and a saturating stall counter.
// Latency: all stall/flush/forward outputs combinational; state and counter registered.
//
// Ports: RA_*/RVal_* source addresses and read flags per stage, WA_*/RegWrite*/
// MemtoReg* destinations, PCSrcE branch, MStartE/MDone multi-cycle handshake,
// ClrCnt counter clear; outputs Stall*/Flush*, ForwardE/ForwardM, MBusy, StallCnt.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int NSRC   = DEF_NSRC,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [NSRC*AW-1:0]   RA_D,
    input  logic [NSRC-1:0]      RVal_D,
    input  logic [NSRC*AW-1:0]   RA_E,
    input  logic [NSRC-1:0]      RVal_E,
    input  logic [AW-1:0]        WA_E,
    input  logic                 RegWriteE,
    input  logic                 MemtoRegE,
    input  logic                 PCSrcE,
    input  logic                 MStartE,
    input  logic                 MDone,
    input  logic [AW-1:0]        WA_M,
    input  logic                 RegWriteM,
    input  logic [AW-1:0]        RA2_M,
    input  logic                 MemWriteM,
    input  logic [AW-1:0]        WA_W,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegW,
    input  logic                 ClrCnt,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic [2*NSRC-1:0]    ForwardE,
    output logic                 ForwardM,
    output logic                 MBusy,
    output logic [CNT_W-1:0]     StallCnt
);

    localparam logic [AW-1:0] PC_A = AW'(PC_REG);

    mc_state_t        r_state;
    mc_state_t        w_state_n;
    logic             w_mcstall;
    logic             w_ldstall;
    logic [NSRC-1:0]  w_ld_hit;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Forwarding selects and load-use detection, one slice per source port
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NSRC; g++) begin : g_port
        logic [1:0] w_fwd;

        hazard_fwd_sel #(
            .AW     (AW),
            .PC_REG (PC_REG)
        ) u_fwd_sel (
            .i_ra         (RA_E[g*AW +: AW]),
            .i_rval       (RVal_E[g]),
            .i_wa_m       (WA_M),
            .i_regwrite_m (RegWriteM),
            .i_wa_w       (WA_W),
            .i_regwrite_w (RegWriteW),
            .o_fwd        (w_fwd)
        );

        assign ForwardE[2*g +: 2] = RESETn ? w_fwd : FWD_RF;

        // A load in E cannot forward to D in time; D must wait one cycle
        assign w_ld_hit[g] = RVal_D[g] && RegWriteE && MemtoRegE &&
                             (RA_D[g*AW +: AW] == WA_E) &&
                             (RA_D[g*AW +: AW] != PC_A);
    end

    assign w_ldstall = |w_ld_hit;

    // Store data arriving from a load one stage ahead
    assign ForwardM = RESETn && MemWriteM && MemtoRegW && RegWriteW &&
                      (RA2_M == WA_W) && (RA2_M != PC_A);

    // ------------------------------------------------------------------
    // Multi-cycle execute handshake
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_mcstall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A taken branch kills the op in E, so it never starts
                if (MStartE && !PCSrcE) begin
                    w_state_n = ST_MC_BUSY;
                    w_mcstall = 1'b1;
                end
            end
            ST_MC_BUSY: begin
                // MDone cycle releases the freeze; MStartE still high for the
                // finishing op must not restart the unit
                if (MDone) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_mcstall = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign MBusy = (r_state == ST_MC_BUSY);

    // ------------------------------------------------------------------
    // Stall / flush priority: multi-cycle freeze, branch, load-use
    // ------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (!RESETn) begin
            StallF = 1'b0;
        end else if (w_mcstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_ldstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt <= '0;
        end else if (ClrCnt) begin
            r_cnt <= '0;
        end else if (StallF && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign StallCnt = r_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int AW     = 4;
    localparam int NSRC   = 3;
    localparam int PCR    = 15;
    localparam int CW     = 5;
    localparam int CNTMAX = (1 << CW) - 1;

    logic                 CLK = 1'b0;
    logic                 RESETn = 1'b0;
    logic [NSRC*AW-1:0]   RA_D, RA_E;
    logic [NSRC-1:0]      RVal_D, RVal_E;
    logic [AW-1:0]        WA_E, WA_M, RA2_M, WA_W;
    logic                 RegWriteE, MemtoRegE, PCSrcE, MStartE, MDone;
    logic                 RegWriteM, MemWriteM, RegWriteW, MemtoRegW, ClrCnt;
    logic                 StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [2*NSRC-1:0]    ForwardE;
    logic                 ForwardM, MBusy;
    logic [CW-1:0]        StallCnt;

    pipeline_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .PC_REG(PCR), .CNT_W(CW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .RA_D(RA_D), .RVal_D(RVal_D), .RA_E(RA_E), .RVal_E(RVal_E),
        .WA_E(WA_E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .MStartE(MStartE), .MDone(MDone),
        .WA_M(WA_M), .RegWriteM(RegWriteM), .RA2_M(RA2_M), .MemWriteM(MemWriteM),
        .WA_W(WA_W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ClrCnt(ClrCnt),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardE(ForwardE), .ForwardM(ForwardM), .MBusy(MBusy), .StallCnt(StallCnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy   = 1'b0;
    bit m_busy_n = 1'b0;
    int m_cnt    = 0;
    int m_cnt_n  = 0;

    function automatic bit hit(input logic [AW-1:0] ra, input bit rv,
                               input logic [AW-1:0] wa, input bit we);
        return rv && we && (ra == wa) && (int'(ra) != PCR);
    endfunction

    always @(negedge CLK) begin
        bit mc, ld, fwm;
        bit [5:0] ectl;            // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
        logic [2*NSRC-1:0] efw;
        if (!RESETn) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end
        mc = m_busy ? !MDone : (MStartE && !PCSrcE);
        ld = 1'b0;
        efw = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (MemtoRegE && hit(RA_D[i*AW +: AW], RVal_D[i], WA_E, RegWriteE)) ld = 1'b1;
            if (hit(RA_E[i*AW +: AW], RVal_E[i], WA_M, RegWriteM))      efw[2*i +: 2] = 2'b10;
            else if (hit(RA_E[i*AW +: AW], RVal_E[i], WA_W, RegWriteW)) efw[2*i +: 2] = 2'b01;
        end
        fwm = MemWriteM && MemtoRegW && RegWriteW && (RA2_M == WA_W) && (int'(RA2_M) != PCR);
        if (!RESETn)     begin ectl = 6'b000000; efw = '0; fwm = 1'b0; end
        else if (mc)     ectl = 6'b111001;
        else if (PCSrcE) ectl = 6'b000110;
        else if (ld)     ectl = 6'b110010;
        else             ectl = 6'b000000;

        chk("ctl", int'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), int'(ectl));
        chk("fwdE", int'(ForwardE), int'(efw));
        chk("fwdM", int'(ForwardM), int'(fwm));
        chk("mbusy", int'(MBusy), int'(m_busy));
        chk("cnt", int'(StallCnt), m_cnt);

        if (!RESETn)     m_busy_n = 1'b0;
        else if (m_busy) m_busy_n = !MDone;
        else             m_busy_n = MStartE && !PCSrcE;
        if (!RESETn || ClrCnt)            m_cnt_n = 0;
        else if (ectl[5] && m_cnt < CNTMAX) m_cnt_n = m_cnt + 1;
        else                               m_cnt_n = m_cnt;
    end

    always @(posedge CLK) begin
        m_busy = m_busy_n;
        m_cnt  = m_cnt_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr_in();
        RA_D = '0; RVal_D = '0; RA_E = '0; RVal_E = '0;
        WA_E = '0; RegWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
        MStartE = 0; MDone = 0; WA_M = '0; RegWriteM = 0;
        RA2_M = '0; MemWriteM = 0; WA_W = '0; RegWriteW = 0; MemtoRegW = 0;
        ClrCnt = 0;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'(PCR);
        return AW'($urandom_range(2, 5));
    endfunction

    int n_st;
    int n_bs;

    initial begin
        clr_in();
        RESETn = 1'b0;
        @(negedge CLK);
        chk("rst_stallF", int'(StallF), 0);
        chk("rst_mbusy", int'(MBusy), 0);
        chk("rst_cnt", int'(StallCnt), 0);
        next(); RESETn = 1'b1;

        // forwarding: M beats W, then W alone
        next(); clr_in();
        RegWriteM = 1; WA_M = 4'd3; RA_E[3:0] = 4'd3; RVal_E[0] = 1;
        RegWriteW = 1; WA_W = 4'd3;
        @(negedge CLK); chk("fwd_M", int'(ForwardE[1:0]), 2);
        next(); RegWriteM = 0;
        @(negedge CLK); chk("fwd_W", int'(ForwardE[1:0]), 1);

        // PC never forwarded; unread port never forwarded
        next(); clr_in();
        RA_E[3:0] = 4'd15; RVal_E[0] = 1; WA_M = 4'd15; RegWriteM = 1;
        @(negedge CLK); chk("fwd_pc", int'(ForwardE), 0);
        next(); RA_E[3:0] = 4'd3; WA_M = 4'd3; RVal_E[0] = 0;
        @(negedge CLK); chk("fwd_rval0", int'(ForwardE), 0);

        // store data from a load in W
        next(); clr_in();
        RA2_M = 4'd7; WA_W = 4'd7; MemWriteM = 1; MemtoRegW = 1; RegWriteW = 1;
        @(negedge CLK); chk("fwdM_hit", int'(ForwardM), 1);

        // load-use: one stall cycle, counter 0 -> 1
        next(); clr_in(); ClrCnt = 1;
        next(); clr_in();
        RegWriteE = 1; MemtoRegE = 1; WA_E = 4'd5; RA_D[7:4] = 4'd5; RVal_D[1] = 1;
        @(negedge CLK);
        chk("ld_ctl", int'({StallF, StallD, StallE, FlushE}), 4'b1101);
        chk("ld_cnt0", int'(StallCnt), 0);
        next(); clr_in();
        @(negedge CLK);
        chk("ld_after", int'(StallF), 0);
        chk("ld_cnt1", int'(StallCnt), 1);

        // multi-cycle op, MDone 4 cycles after entry
        next(); clr_in(); ClrCnt = 1;
        n_st = 0; n_bs = 0;
        for (int k = 0; k <= 4; k++) begin
            next(); clr_in();
            MStartE = 1; MDone = (k == 4);
            @(negedge CLK);
            if (StallF && StallD && StallE && FlushM && !FlushD && !FlushE) n_st++;
            if (MBusy && StallF) n_bs++;
        end
        next(); clr_in();
        @(negedge CLK);
        chk("mc_stalls", n_st, 4);
        chk("mc_busy_stalled", n_bs, 3);
        chk("mc_idle", int'(MBusy), 0);
        chk("mc_cnt", int'(StallCnt), 4);

        // branch overrides load-use
        next(); clr_in();
        RegWriteE = 1; MemtoRegE = 1; WA_E = 4'd5; RA_D[3:0] = 4'd5; RVal_D[0] = 1;
        PCSrcE = 1;
        @(negedge CLK);
        chk("br_flush", int'({FlushD, FlushE}), 3);
        chk("br_nostall", int'(StallF), 0);

        // reset during MC_BUSY
        next(); clr_in(); MStartE = 1;
        next(); MStartE = 1;
        @(negedge CLK); chk("rb_busy", int'(MBusy), 1);
        next(); RESETn = 0;
        @(negedge CLK);
        chk("rb_outs", int'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), 0);
        chk("rb_mbusy", int'(MBusy), 0);
        chk("rb_cnt", int'(StallCnt), 0);
        next(); RESETn = 1; MStartE = 0;
        @(negedge CLK);
        chk("rb_release", int'({StallF, MBusy}), 0);

        // saturation, then clear wins over increment
        next(); clr_in(); MStartE = 1;
        repeat (CNTMAX + 5) next();
        @(negedge CLK); chk("sat", int'(StallCnt), CNTMAX);
        next(); ClrCnt = 1;
        @(negedge CLK); chk("clr_stalling", int'(StallF), 1);
        next(); ClrCnt = 0; MDone = 1;
        @(negedge CLK); chk("clr_cnt", int'(StallCnt), 0);

        // randomized phase
        for (int c = 0; c < 800; c++) begin
            next();
            RESETn    = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < NSRC; i++) begin
                RA_D[i*AW +: AW] = rnd_addr();
                RA_E[i*AW +: AW] = rnd_addr();
            end
            RVal_D    = NSRC'($urandom);
            RVal_E    = NSRC'($urandom);
            WA_E      = rnd_addr();
            WA_M      = rnd_addr();
            WA_W      = rnd_addr();
            RA2_M     = rnd_addr();
            RegWriteE = $urandom_range(0, 1) != 0;
            MemtoRegE = $urandom_range(0, 2) == 0;
            RegWriteM = $urandom_range(0, 1) != 0;
            MemWriteM = $urandom_range(0, 1) != 0;
            RegWriteW = $urandom_range(0, 1) != 0;
            MemtoRegW = $urandom_range(0, 1) != 0;
            PCSrcE    = $urandom_range(0, 5) == 0;
            MStartE   = m_busy ? 1'b1 : ($urandom_range(0, 5) == 0);
            MDone     = m_busy && ($urandom_range(0, 3) == 0);
            ClrCnt    = $urandom_range(0, 40) == 0;
        end

        next(); clr_in();
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
